// File: rtl/array_ctrl_pkg.sv
// Shared sizing and FSM encoding for the two-port RAM array controller.
package array_ctrl_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 137;
    localparam int DEPTH  = 4096;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/array_19_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            if (i_valid == 2'b11)
                o_grant = r_last ? 2'b01 : 2'b10;
            else
                o_grant = i_valid;
        end
    end

    // Pointer resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_last <= 1'b1;
        else if (|o_grant)
            r_last <= o_grant[1];
    end
endmodule

// File: rtl/array_19_ctrl.sv
// RAM front-end: zero-fills the external RAM after reset, then arbitrates two
// requesters onto the single RAM port with one-cycle read responses.
module array_19_ctrl #(
    parameter int ADDR_W = array_ctrl_pkg::ADDR_W,
    parameter int DATA_W = array_ctrl_pkg::DATA_W,
    parameter int DEPTH  = array_ctrl_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_wmode,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    import array_ctrl_pkg::*;

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W:0]   r_init_cnt;
    logic              r_init_done;
    logic [1:0]        r_resp_vld;
    logic [1:0]        w_grant;
    logic              w_run;

    assign w_run = (r_state == RUN);

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (w_run),
        .i_valid ({req1_valid, req0_valid}),
        .o_grant (w_grant)
    );

    assign req0_ready  = w_grant[0];
    assign req1_ready  = w_grant[1];
    assign resp0_valid = r_resp_vld[0];
    assign resp1_valid = r_resp_vld[1];
    assign resp_rdata  = ram_rdata;
    assign init_done   = r_init_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_resp_vld  <= 2'b00;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Grant is only ever raised in RUN, so INIT yields no responses.
            r_resp_vld <= w_grant & ~{req1_write, req0_write};
        end
    end

    // RAM port is driven combinationally so accepted requests see no extra latency.
    always_comb begin
        ram_en    = 1'b0;
        ram_wmode = 1'b0;
        ram_addr  = r_init_cnt[ADDR_W-1:0];
        ram_wdata = '0;
        if (r_state == INIT) begin
            ram_en    = reset_n;
            ram_wmode = 1'b1;
        end else if (w_grant[0]) begin
            ram_en    = 1'b1;
            ram_wmode = req0_write;
            ram_addr  = req0_addr;
            ram_wdata = req0_wdata;
        end else if (w_grant[1]) begin
            ram_en    = 1'b1;
            ram_wmode = req1_write;
            ram_addr  = req1_addr;
            ram_wdata = req1_wdata;
        end
    end
endmodule

// File: doc/array_19_ctrl.md
ARRAY_19_CTRL -- requirements
Module: array_19_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 137, RAM word width.
REQ-003 SHALL have parameter DEPTH, default 4096, number of RAM words (2**ADDR_W).
REQ-004 SHALL have port clock  input  1  the single clock for all logic and the RAM.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports reqN_valid  input  1  request valid, for N = 0,1.
REQ-007 SHALL have ports reqN_ready  output  1  request accepted this cycle, for N = 0,1.
REQ-008 SHALL have ports reqN_write  input  1  1 = write, 0 = read, for N = 0,1.
REQ-009 SHALL have ports reqN_addr  input  ADDR_W  word address, for N = 0,1.
REQ-010 SHALL have ports reqN_wdata  input  DATA_W  write data, for N = 0,1.
REQ-011 SHALL have ports respN_valid  output  1  read data valid, for N = 0,1.
REQ-012 SHALL have port resp_rdata  output  DATA_W  read data, shared by both requesters.
REQ-013 SHALL have port init_done  output  1  RAM zero-fill complete.
REQ-014 SHALL have RAM-side ports ram_addr (ADDR_W), ram_en (1), ram_wmode (1) and ram_wdata (DATA_W) as outputs, and ram_rdata (DATA_W) as input.

Function
REQ-015 SHALL implement FSM states INIT and RUN; INIT is entered on reset.
REQ-016 In INIT, SHALL drive ram_en=1, ram_wmode=1, ram_wdata=0 and ram_addr=init_cnt, and SHALL increment init_cnt every cycle.
REQ-017 SHALL transition INIT->RUN on the cycle after the write to address DEPTH-1, and SHALL set init_done=1 from that cycle onward.
REQ-018 In INIT, SHALL hold both reqN_ready at 0.
REQ-019 In RUN, SHALL grant at most one request per cycle; reqN_ready SHALL be a combinational function of the valids and the round-robin pointer.
REQ-020 Acceptance SHALL be defined as reqN_valid && reqN_ready in the same cycle.
REQ-021 Arbitration: with a single valid, that requester SHALL be granted; with both valid, the requester not granted most recently SHALL be granted.
REQ-022 The last-grant pointer SHALL reset to 1, so that requester 0 wins the first contention.
REQ-023 On acceptance, SHALL drive ram_en=1, ram_wmode=reqN_write, ram_addr=reqN_addr and ram_wdata=reqN_wdata in that same cycle, with no added latency.
REQ-024 When no request is accepted, SHALL drive ram_en=0.
REQ-025 For an accepted read, SHALL assert respN_valid for exactly one cycle, in the cycle following acceptance, with resp_rdata=ram_rdata.
REQ-026 An accepted write SHALL produce no response.
REQ-027 A read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-028 Responses SHALL NOT be backpressured; the responder SHALL accept responses unconditionally.
REQ-029 Back-to-back accepted reads SHALL yield one response per cycle.
REQ-030 init_cnt SHALL be ADDR_W+1 bits wide so the terminal count is unambiguous; no wrap-around SHALL occur in init_cnt.
REQ-031 Requester addresses SHALL span the full range 0..DEPTH-1.

Reset
REQ-032 reset_n low SHALL asynchronously force: FSM=INIT, init_cnt=0, init_done=0, last-grant pointer=1, respN_valid=0, and the registered response-owner state cleared.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL restart the zero-fill from address 0 and SHALL discard any pending read response.
REQ-034 ram_en SHALL be 0 while reset_n is low.

Structure
REQ-035 ADDR_W, DATA_W, DEPTH and the FSM state encoding (INIT, RUN) SHALL reside in the shared package array_ctrl_pkg.
REQ-036 The round-robin grant logic SHALL be the single sub-module rr_arb2.
REQ-037 The RAM macro SHALL be instantiated outside this block.

Verification
REQ-038 Release reset, no requests -> ram_en=1 for 4096 cycles writing zeros to addresses 0..4095; init_done=1 on cycle 4096; reads of 0x000 and 0xFFF return 0.
REQ-039 req0 writes 0x1_2345_6789_ABCD at address 0xFFF, then reads 0xFFF on the next cycle -> resp0_valid one cycle after the read, resp_rdata=0x1_2345_6789_ABCD, resp1_valid=0.
REQ-040 Both requesters hold valid reads for 4 cycles -> grants alternate 0,1,0,1; responses alternate resp0_valid/resp1_valid, each with the correct data.
REQ-041 Requester 1 alone valid for 3 cycles, then both valid -> requester 0 is granted on the first contended cycle.
REQ-042 Assert reset_n low one cycle after a read is accepted in RUN -> no respN_valid pulse; init_done=0; zero-fill restarts at address 0.
REQ-043 Assert reset_n low at init_cnt=2000 -> init_cnt=0 immediately; a full 4096-cycle fill follows before init_done=1.
